// File: rtl/ram_arb_pkg.sv
// Shared constants and helpers for the RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned DefDWidth = 16;
    localparam int unsigned DefAWidth = 4;
    localparam int unsigned DefNReq   = 2;
    localparam int unsigned MaxReq    = 8;

    // Index of the set bit in a one-hot vector; 0 when the vector is empty.
    function automatic int unsigned onehot_to_idx(input logic [MaxReq-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at a registered pointer.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [MaxReq-1:0] gnt_ext;
    logic              found;
    int unsigned       idx;
    int unsigned       win;

    // Pick the first requester at or after the pointer, wrapping; no grants in reset.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr_q) + i) % N;
            if (rst_n && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner; holds when nothing is granted.
    always_comb begin
        ptr_d            = ptr_q;
        gnt_ext          = '0;
        gnt_ext[N-1:0]   = gnt;
        win              = onehot_to_idx(gnt_ext);
        if (|gnt) begin
            ptr_d = (win == N - 1) ? '0 : PW'(win + 1);
        end
    end

    // Pointer register with synchronous reset to requester 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one dual-port RAM among N_REQ requesters with independent round-robin
// arbitration on the write and read ports. Optional macro RAM_ARB_BYPASS_EN forwards
// same-cycle write data to a colliding read.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned D_WIDTH = DefDWidth,
    parameter int unsigned A_WIDTH = DefAWidth,
    parameter int unsigned N_REQ   = DefNReq
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           wr_req,
    input  logic [N_REQ*A_WIDTH-1:0]   wr_addr,
    input  logic [N_REQ*D_WIDTH-1:0]   wr_data,
    output logic [N_REQ-1:0]           wr_gnt,
    input  logic [N_REQ-1:0]           rd_req,
    input  logic [N_REQ*A_WIDTH-1:0]   rd_addr,
    output logic [N_REQ-1:0]           rd_gnt,
    output logic [N_REQ-1:0]           rd_valid,
    output logic [D_WIDTH-1:0]         rd_data,
    output logic [A_WIDTH-1:0]         ram_address_write,
    output logic [D_WIDTH-1:0]         ram_data_write,
    output logic                       ram_write_enable,
    output logic [A_WIDTH-1:0]         ram_address_read,
    input  logic [D_WIDTH-1:0]         ram_data_read
);

    logic [N_REQ-1:0] rd_tag_q;

    rr_arbiter #(
        .N (N_REQ)
    ) u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req),
        .gnt   (wr_gnt)
    );

    rr_arbiter #(
        .N (N_REQ)
    ) u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    // Route the granted slices to the RAM; zero when the port is idle.
    always_comb begin
        ram_write_enable  = |wr_gnt;
        ram_address_write = '0;
        ram_data_write    = '0;
        ram_address_read  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (wr_gnt[i]) begin
                ram_address_write = wr_addr[i*A_WIDTH +: A_WIDTH];
                ram_data_write    = wr_data[i*D_WIDTH +: D_WIDTH];
            end
            if (rd_gnt[i]) begin
                ram_address_read = rd_addr[i*A_WIDTH +: A_WIDTH];
            end
        end
    end

    // One-cycle read tag: remembers who owns the data the RAM returns next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_tag_q <= '0;
        end else begin
            rd_tag_q <= rd_gnt;
        end
    end

    assign rd_valid = rd_tag_q;

`ifdef RAM_ARB_BYPASS_EN
    logic               byp_d;
    logic               byp_q;
    logic [D_WIDTH-1:0] byp_data_q;

    assign byp_d = (|wr_gnt) && (|rd_gnt) && (ram_address_write == ram_address_read);

    // Capture write data when a granted read hits the address being written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_q      <= byp_d;
            byp_data_q <= ram_data_write;
        end
    end

    // Return forwarded data on a collision, otherwise the RAM output.
    always_comb begin
        rd_data = '0;
        if (|rd_tag_q) begin
            rd_data = byp_q ? byp_data_q : ram_data_read;
        end
    end
`else
    // Return the RAM output only while a read result is owned.
    always_comb begin
        rd_data = '0;
        if (|rd_tag_q) begin
            rd_data = ram_data_read;
        end
    end
`endif

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Single-clock round-robin arbiter that shares one dual-port `ram` (16x16, separate write and read ports) among `N_REQ` requesters. Write and read ports are arbitrated independently, so one write and one read can issue per cycle. Read data returns to the granted requester with a one-hot valid tag. It sits between client engines and the `ram` instance, with both `ram` clocks tied to `clk`.

## Interface
- `D_WIDTH`, default 16: data width; must match `ram`.
- `A_WIDTH`, default 4: address width; must match `ram`.
- `N_REQ`, default 2: number of requesters, 2..8.

Ports:
- `clk`  in  1  single clock; also drives `ram` `clk_write` and `clk_read`.
- `rst_n`  in  1  synchronous reset, active-low.
- `wr_req`  in  N_REQ  per-requester write request.
- `wr_addr`  in  N_REQ*A_WIDTH  packed write addresses; requester i uses slice i.
- `wr_data`  in  N_REQ*D_WIDTH  packed write data.
- `wr_gnt`  out  N_REQ  one-hot write grant.
- `rd_req`  in  N_REQ  per-requester read request.
- `rd_addr`  in  N_REQ*A_WIDTH  packed read addresses.
- `rd_gnt`  out  N_REQ  one-hot read grant.
- `rd_valid`  out  N_REQ  one-hot read-data valid.
- `rd_data`  out  D_WIDTH  read data, shared by all requesters.
- `ram_address_write`  out  A_WIDTH  to `ram`.
- `ram_data_write`  out  D_WIDTH  to `ram`.
- `ram_write_enable`  out  1  to `ram`.
- `ram_address_read`  out  A_WIDTH  to `ram`.
- `ram_data_read`  in  D_WIDTH  from `ram`.

## Operation
- **Handshake:** a requester raises `*_req` with its address (and data, for writes) and holds them stable until the matching `*_gnt` is high.
  - The transfer completes in the cycle `gnt`=1.
  - The requester may drop `req` or present a new request in the next cycle.
- **Grants:** grants are combinational from `req` and a registered pointer. At most one bit of each grant vector is set.
- **Round-robin:** each port has its own pointer `wr_ptr` / `rd_ptr`.
  - The search starts at the pointer index and wraps modulo N_REQ.
  - On a grant to requester k, the pointer becomes (k+1) mod N_REQ.
  - With no grant, the pointer holds.
  - A held request is granted within N_REQ cycles.
- **Write port:**
  - `ram_write_enable` = |`wr_gnt`.
  - `ram_address_write` / `ram_data_write` are muxed from the granted slice, and are zero when there is no grant.
- **Read port:**
  - `ram_address_read` is muxed from the granted slice.
  - A registered one-hot tag, loaded from `rd_gnt`, drives `rd_valid` in the next cycle.
  - `rd_data` = `ram_data_read` whenever any `rd_valid` bit is set, else 0.
- **Same-address read/write in the same cycle (macro off):** the read returns the old memory contents.
- **Reset** (`rst_n`=0 at a clock edge):
  - Pointers go to 0 and the tag register is cleared.
  - While `rst_n`=0, all grants and `ram_write_enable` are forced to 0.
  - A read granted in the cycle before reset is discarded: `rd_valid` stays 0 after reset.

## Timing
- Grant latency is 0 cycles: the grant is in the same cycle as `req` when the requester wins.
- Read latency is 1 cycle: `rd_gnt[i]` high in cycle T gives `rd_valid[i]` high and `rd_data` valid in cycle T+1 only.
- Back-to-back reads from the same or different requesters give one `rd_valid` per cycle.
- Writes update memory at the edge ending the grant cycle. A read granted in T+1 sees the new data.
- Reset values:
  - `wr_gnt`, `rd_gnt`, `rd_valid` = 0.
  - `rd_data` = 0.
  - `ram_write_enable` = 0.
  - RAM address and data outputs = 0.
  - After reset, requester 0 has highest priority on both ports.

## Configuration
- Macro `RAM_ARB_BYPASS_EN` defined:
  - Applies when the granted read and the granted write in the same cycle T target the same address.
  - The write data is registered with a bypass flag.
  - In T+1, `rd_data` returns the new write data instead of `ram_data_read`.
- Macro undefined: no bypass logic; the same-cycle collision returns old data.

## Structure
- Package `ram_arb_pkg` holds:
  - the default `D_WIDTH` / `A_WIDTH` / `N_REQ` constants;
  - a helper function for the one-hot to index conversion.
- Sub-module `rr_arbiter` (parameter N): `req`, pointer state, one-hot `gnt`, `clk`/`rst_n`. It is instantiated twice, once for writes and once for reads.
- `ram_arbiter` itself contains the muxes, the read tag register and the optional bypass register.

## Test plan
- **Reset:** hold `rst_n`=0 with all requests high. All grants, `ram_write_enable` and `rd_valid` must be 0. After release, the first grants go to requester 0.
- **Write fairness:** with N_REQ=2, both `wr_req` are held high for 4 cycles. `wr_gnt` must go 01, 10, 01, 10, and `ram_write_enable`=1 each cycle.
- **Write then read:** requester 1 writes 0xBEEF to address 3 in cycle T. Requester 0 reads address 3 in T+1. `rd_valid`=01 and `rd_data`=0xBEEF in T+2.
- **Same-cycle collision:** address 5 holds 0x1111. In the same cycle, write 0x2222 and read address 5.
  - Without `RAM_ARB_BYPASS_EN`: `rd_data`=0x1111.
  - With it: 0x2222.
- **Reset with read in flight:** `rd_gnt`=10 in cycle T, `rst_n`=0 at the T+1 edge. `rd_valid` must be 0 after the edge, with no stale read delivered.
- **Independent ports:** reads and writes from different requesters are issued simultaneously for 8 cycles.
  - Each port rotates independently.
  - Exactly one `rd_valid` appears per read grant, each one cycle later.
